// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- definitions shared by control_unit and cpu_datapath.
//
// Contents:
//   ALU_*           alu_select operation codes
//   MUX_*           mux_select accumulator-source codes
//   alu_sets_carry  true for the add/subtract family, whose carry or borrow
//                   is kept by the optional carry flag
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_AND    = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0011;
   localparam logic [3:0] ALU_SUB    = 4'b0100;
   localparam logic [3:0] ALU_INC    = 4'b0101;
   localparam logic [3:0] ALU_DEC    = 4'b0110;
   localparam logic [3:0] ALU_ROTR   = 4'b0111;
   localparam logic [3:0] ALU_SLT    = 4'b1000;
   localparam logic [3:0] ALU_PASS_B = 4'b1001;

   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_RF  = 2'b01;
   localparam logic [1:0] MUX_IMM = 2'b10;
   localparam logic [1:0] MUX_IN  = 2'b11;

   function automatic logic alu_sets_carry(input logic [3:0] sel);
      return (sel == ALU_ADD) || (sel == ALU_INC) ||
             (sel == ALU_SUB) || (sel == ALU_DEC);
   endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// ---------------------------------------------------------------------------
// cpu_datapath_if -- output stream from the datapath FIFO to the display.
//
// Signals:
//   out_data      FIFO head value
//   out_valid     FIFO holds at least one entry
//   out_ready     display consumes the head this edge
//   out_overflow  sticky: a push was dropped on a full FIFO
// Modports: master = datapath (drives data/valid/overflow),
//           slave  = display  (drives ready).
// ---------------------------------------------------------------------------
interface cpu_datapath_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_overflow;

   modport master (output out_data, output out_valid, output out_overflow,
                   input  out_ready);
   modport slave  (input  out_data, input  out_valid, input  out_overflow,
                   output out_ready);
endinterface

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu -- purely combinational ALU of the datapath.
//
// Ports:
//   i_a       accumulator operand
//   i_b       register-file operand
//   i_select  operation code (cpu_pkg::ALU_*); unknown codes give 0
//   i_rotate  rotate-right amount for ALU_ROTR
//   o_result  operation result
//   o_carry   carry-out for ADD/INC, borrow for SUB/DEC, else 0
// ---------------------------------------------------------------------------
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [3:0]        i_select,
   input  logic [1:0]        i_rotate,
   output logic [DATA_W-1:0] o_result,
   output logic              o_carry
);

   logic signed [DATA_W-1:0] w_a_s;
   logic signed [DATA_W-1:0] w_b_s;

   assign w_a_s = i_a;
   assign w_b_s = i_b;

   // Arithmetic is done one bit wider so the top bit is the carry (add)
   // or the borrow (subtract, which wraps the extended result negative).
   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_select)
         ALU_PASS_A: o_result = i_a;
         ALU_AND:    o_result = i_a & i_b;
         ALU_ADD:    {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
         ALU_SUB:    {o_carry, o_result} = {1'b0, i_a} - {1'b0, i_b};
         ALU_INC:    {o_carry, o_result} = {1'b0, i_a} + (DATA_W + 1)'(1);
         ALU_DEC:    {o_carry, o_result} = {1'b0, i_a} - (DATA_W + 1)'(1);
         // A rotate of 0 makes the left shift DATA_W wide, which yields 0.
         ALU_ROTR:   o_result = (i_a >> i_rotate) | (i_a << (DATA_W - i_rotate));
         ALU_SLT:    o_result = {{(DATA_W-1){1'b0}}, (w_a_s < w_b_s)};
         ALU_PASS_B: o_result = i_b;
         default:    o_result = '0;
      endcase
   end

endmodule

// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath -- execution datapath driven by control_unit one cycle at a
// time: accumulator, register file, ALU and an output FIFO to the display.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   mux_select       accumulator source (cpu_pkg::MUX_*)
//   acc_enable       load accumulator from the mux
//   rf_write         RF[rf_address] <= accumulator (pre-update value)
//   rf_address       RF read/write index
//   alu_select       ALU operation, alu_num_rotate: ROTR amount
//   output_enable    push accumulator (pre-update value) into the FIFO
//   imm_data         immediate operand, in_data: switch input (registered)
//   out_if           FIFO output stream (master modport)
//   alu_result       combinational ALU output
//   zero_flag        accumulator == 0
//   positive_flag    accumulator signed > 0
//   carry_flag       only with CPU_DATAPATH_CARRY_FLAG_EN defined: carry or
//                    borrow of the last ADD/INC/SUB/DEC accumulator load
// ---------------------------------------------------------------------------
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int RF_AW       = 3,
   parameter int OFIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        mux_select,
   input  logic              acc_enable,
   input  logic              rf_write,
   input  logic [RF_AW-1:0]  rf_address,
   input  logic [3:0]        alu_select,
   input  logic [1:0]        alu_num_rotate,
   input  logic              output_enable,
   input  logic [DATA_W-1:0] imm_data,
   input  logic [DATA_W-1:0] in_data,
   cpu_datapath_if.master    out_if,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero_flag,
   output logic              positive_flag
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
   ,
   output logic              carry_flag
`endif
);

   localparam int RF_N  = 2 ** RF_AW;
   localparam int PTR_W = $clog2(OFIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_in_q;
   logic [DATA_W-1:0] r_rf [RF_N];
   logic [DATA_W-1:0] r_mem [OFIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;

   logic [DATA_W-1:0] w_rf_b;
   logic [DATA_W-1:0] w_mux;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
   logic              w_alu_carry;
   logic              r_carry;
`else
   logic              w_alu_carry_unused;
`endif

   assign w_rf_b = r_rf[rf_address];

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .i_a      (r_acc),
      .i_b      (w_rf_b),
      .i_select (alu_select),
      .i_rotate (alu_num_rotate),
      .o_result (alu_result),
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
      .o_carry  (w_alu_carry)
`else
      .o_carry  (w_alu_carry_unused)
`endif
   );

   always_comb begin
      w_mux = r_in_q;
      case (mux_select)
         MUX_ALU: w_mux = alu_result;
         MUX_RF:  w_mux = w_rf_b;
         MUX_IMM: w_mux = imm_data;
         default: w_mux = r_in_q;
      endcase
   end

   assign zero_flag     = (r_acc == '0);
   assign positive_flag = !r_acc[DATA_W-1] && (r_acc != '0);

   // in_data is sampled every edge so MUX_IN never forms a pin-to-register
   // combinational path; it loads the value seen on the previous edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc  <= '0;
         r_in_q <= '0;
      end else begin
         r_in_q <= in_data;
         if (acc_enable) r_acc <= w_mux;
      end
   end

`ifdef CPU_DATAPATH_CARRY_FLAG_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_carry <= 1'b0;
      else if (acc_enable)
         r_carry <= (mux_select == MUX_ALU) && alu_sets_carry(alu_select) && w_alu_carry;
   end
   assign carry_flag = r_carry;
`endif

   // The RF stores the accumulator as it was before this edge, so a
   // combined rf_write + acc_enable saves the old value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RF_N; i++) r_rf[i] <= '0;
      end else if (rf_write) begin
         r_rf[rf_address] <= r_acc;
      end
   end

   // Output FIFO: a push on a full FIFO is accepted only when the head is
   // popped on the same edge; otherwise it is dropped and flagged.
   assign w_full = (r_count == CNT_W'(OFIFO_DEPTH));
   assign w_pop  = out_if.out_valid && out_if.out_ready;
   assign w_push = output_enable && (!w_full || w_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < OFIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= r_acc;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (output_enable && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign out_if.out_data     = r_mem[r_rptr];
   assign out_if.out_valid    = (r_count != '0);
   assign out_if.out_overflow = r_overflow;

endmodule

// File: tb/tb_cpu_datapath.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath -- directed-vector bench for cpu_datapath.
// Inputs change 1 time unit after the rising edge; outputs are checked
// there too, away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_datapath;
   import cpu_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] mux_select = 2'b00;
   logic       acc_enable = 1'b0;
   logic       rf_write = 1'b0;
   logic [2:0] rf_address = 3'd0;
   logic [3:0] alu_select = 4'd0;
   logic [1:0] alu_num_rotate = 2'd0;
   logic       output_enable = 1'b0;
   logic [7:0] imm_data = 8'd0;
   logic [7:0] in_data = 8'd0;
   logic [7:0] alu_result;
   logic       zero_flag;
   logic       positive_flag;
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
   logic       carry_flag;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   cpu_datapath_if #(.DATA_W(8)) dp_if ();

   cpu_datapath #(.DATA_W(8), .RF_AW(3), .OFIFO_DEPTH(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .mux_select     (mux_select),
      .acc_enable     (acc_enable),
      .rf_write       (rf_write),
      .rf_address     (rf_address),
      .alu_select     (alu_select),
      .alu_num_rotate (alu_num_rotate),
      .output_enable  (output_enable),
      .imm_data       (imm_data),
      .in_data        (in_data),
      .out_if         (dp_if.master),
      .alu_result     (alu_result),
      .zero_flag      (zero_flag),
      .positive_flag  (positive_flag)
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
      ,
      .carry_flag     (carry_flag)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      mux_select    = MUX_ALU;
      acc_enable    = 1'b0;
      rf_write      = 1'b0;
      alu_select    = ALU_PASS_A;
      output_enable = 1'b0;
   endtask

   task automatic load_imm(input logic [7:0] v);
      mux_select = MUX_IMM; imm_data = v; acc_enable = 1'b1;
      tick();
      idle();
   endtask

   task automatic alu_op(input logic [3:0] sel, input logic [2:0] addr);
      mux_select = MUX_ALU; alu_select = sel; rf_address = addr; acc_enable = 1'b1;
      tick();
      idle();
   endtask

   task automatic rf_store(input logic [2:0] addr);
      rf_address = addr; rf_write = 1'b1;
      tick();
      idle();
   endtask

   task automatic push();
      output_enable = 1'b1;
      tick();
      idle();
   endtask

   // Accumulator is observed through the ALU pass-through of A.
   task automatic chk_acc(input string tag, input logic [7:0] exp);
      alu_select = ALU_PASS_A;
      #1;
      check(tag, alu_result, exp);
   endtask

   task automatic chk_rf(input string tag, input logic [2:0] addr, input logic [7:0] exp);
      alu_select = ALU_PASS_B; rf_address = addr;
      #1;
      check(tag, alu_result, exp);
      alu_select = ALU_PASS_A;
   endtask

   initial begin
      dp_if.out_ready = 1'b0;
      // Power-on reset
      #1 reset = 1'b1;
      #2;
      check("rst_zero", zero_flag, 1);
      check("rst_pos", positive_flag, 0);
      check("rst_valid", dp_if.out_valid, 0);
      check("rst_data", dp_if.out_data, 0);
      check("rst_ovf", dp_if.out_overflow, 0);
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
      check("rst_carry", carry_flag, 0);
`endif
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      tick();

      // ADD through the register file
      load_imm(8'h05);
      rf_store(3'd3);
      load_imm(8'h03);
      alu_op(ALU_ADD, 3'd3);
      chk_acc("add_acc", 8'h08);
      check("add_pos", positive_flag, 1);
      check("add_zero", zero_flag, 0);
      chk_rf("rf3", 3'd3, 8'h05);

      // rf_write together with acc_enable stores the old accumulator
      mux_select = MUX_IMM; imm_data = 8'h09; acc_enable = 1'b1;
      rf_write = 1'b1; rf_address = 3'd4;
      tick();
      idle();
      chk_rf("rf_old_acc", 3'd4, 8'h08);
      chk_acc("acc_new", 8'h09);

      // DEC to zero, then wrap to FF
      load_imm(8'h01);
      alu_op(ALU_DEC, 3'd0);
      chk_acc("dec_zero", 8'h00);
      check("dec_zflag", zero_flag, 1);
      alu_op(ALU_DEC, 3'd0);
      chk_acc("dec_wrap", 8'hFF);
      check("dec_pos", positive_flag, 0);
      check("dec_nz", zero_flag, 0);
`ifdef CPU_DATAPATH_CARRY_FLAG_EN
      check("dec_borrow", carry_flag, 1);
      load_imm(8'h02);
      check("carry_clr", carry_flag, 0);
`endif

      // in_data is loaded as sampled one edge earlier
      in_data = 8'h3C;
      tick();
      in_data = 8'h00; mux_select = MUX_IN; acc_enable = 1'b1;
      tick();
      idle();
      chk_acc("in_data", 8'h3C);

      // ROTR and SLT
      load_imm(8'h01);
      rf_store(3'd1);
      load_imm(8'h81);
      alu_num_rotate = 2'd1;
      alu_op(ALU_ROTR, 3'd0);
      chk_acc("rotr", 8'hC0);
      alu_op(ALU_SLT, 3'd1);
      chk_acc("slt", 8'h01);
      alu_select = 4'b0010;
      #1 check("bad_op", alu_result, 0);
      load_imm(8'h5A);
      rf_store(3'd2);
      load_imm(8'h3C);
      alu_select = ALU_AND; rf_address = 3'd2;
      #1 check("and", alu_result, 8'h18);
      alu_select = ALU_SUB;
      #1 check("sub", alu_result, 8'hE2);
      idle();

      // Overflow: five pushes into a 4-deep FIFO with no consumer
      for (int v = 1; v <= 5; v++) begin
         load_imm(8'(v));
         push();
      end
      check("ovf_set", dp_if.out_overflow, 1);
      check("ovf_valid", dp_if.out_valid, 1);
      dp_if.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         #1 check($sformatf("drain%0d", k), dp_if.out_data, 8'(k));
         tick();
      end
      check("drain_empty", dp_if.out_valid, 0);
      dp_if.out_ready = 1'b0;

      // Asynchronous reset with three entries held
      for (int v = 7; v <= 9; v++) begin
         load_imm(8'(v));
         push();
      end
      check("held3", dp_if.out_valid, 1);
      reset = 1'b1;
      #1;
      check("mid_valid", dp_if.out_valid, 0);
      check("mid_zero", zero_flag, 1);
      check("mid_ovf", dp_if.out_overflow, 0);
      for (int a = 0; a < 8; a++) chk_rf($sformatf("mid_rf%0d", a), 3'(a), 8'h00);
      @(posedge clock);
      #1 reset = 1'b0;
      tick();

      // Full FIFO: push and pop on the same edge
      for (int v = 'h11; v <= 'h14; v++) begin
         load_imm(8'(v));
         push();
      end
      load_imm(8'h15);
      check("full_head", dp_if.out_data, 8'h11);
      dp_if.out_ready = 1'b1; output_enable = 1'b1;
      tick();
      idle();
      check("pp_ovf", dp_if.out_overflow, 0);
      for (int k = 'h12; k <= 'h15; k++) begin
         #1 check($sformatf("pp_drain%0h", k), dp_if.out_data, 8'(k));
         check($sformatf("pp_valid%0h", k), dp_if.out_valid, 1);
         tick();
      end
      check("pp_empty", dp_if.out_valid, 0);
      tick();
      check("pop_empty", dp_if.out_valid, 0);
      check("pop_empty_ovf", dp_if.out_overflow, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Execution datapath directly downstream of control_unit. Consumes its control word (mux_select, acc_enable, rf_write, rf_address, alu_select, alu_num_rotate, output_enable) plus imm_data.
- Holds the accumulator, an 8-entry register file, the ALU and a small output FIFO.
- Returns alu_result, zero_flag and positive_flag to control_unit.
- Drains OUTA/STA values to the board display through a valid/ready handshake.

Parameters:
- DATA_W, 8, datapath width in bits.
- RF_AW, 3, register-file address width; gives 2**RF_AW entries.
- OFIFO_DEPTH, 4, output FIFO entries; must be a power of 2, >= 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mux_select  in  2  accumulator source: 00 ALU, 01 RF[rf_address], 10 imm_data, 11 in_data.
- acc_enable  in  1  load the accumulator from the mux this edge.
- rf_write  in  1  write accumulator to RF[rf_address] this edge.
- rf_address  in  RF_AW  RF read/write index.
- alu_select  in  4  ALU operation code.
- alu_num_rotate  in  2  rotate-right amount for ROTR.
- output_enable  in  1  push accumulator into the output FIFO.
- imm_data  in  DATA_W  immediate operand.
- in_data  in  DATA_W  external switch input.
- alu_result  out  DATA_W  combinational ALU output.
- zero_flag  out  1  accumulator == 0.
- positive_flag  out  1  accumulator signed > 0.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  display consumes the head.
- out_overflow  out  1  sticky: a push was dropped while the FIFO was full.

Behaviour:
- Reset (asynchronous): accumulator=0, all RF entries=0, FIFO pointers and count=0, out_overflow=0, in_data sample register=0.
  - Resulting outputs: zero_flag=1, positive_flag=0, out_valid=0, out_data=0.
- ALU is combinational. A=accumulator, B=RF[rf_address].
  - 0000 A; 0001 A&B; 0011 A+B (mod 2^DATA_W); 0100 A-B (mod); 0101 A+1; 0110 A-1.
  - 0111 A rotated right by alu_num_rotate; 1000 SLT: 1 if signed A<signed B, else 0; 1001 B (relative-branch offset).
  - Any other code: 0.
- Accumulator, edge with acc_enable=1: acc <= mux output. in_data is registered one cycle earlier to avoid a combinational path from the pins, so mux 11 loads in_data as sampled on the previous edge.
- RF, edge with rf_write=1: RF[rf_address] <= acc value before this edge's update.
  - rf_write and acc_enable together: RF gets the old acc.
  - ALU/mux reads of the same address see the old RF value (write-then-read next cycle).
- Flags are combinational from the accumulator register: zero_flag=(acc==0), positive_flag=(!acc[DATA_W-1] && acc!=0).
  - Flags update the cycle after acc loads. control_unit samples them in EXECUTE, one cycle after the prior instruction's EXECUTE edge.
- Output FIFO: push = output_enable; value = acc before this edge's update. pop = out_valid && out_ready.
  - Push on full without a simultaneous pop: data dropped, out_overflow <= 1 (cleared only by reset).
  - Push and pop on full: both occur, count unchanged, no overflow.
  - Pop on empty: ignored.
- FIFO pointers wrap modulo OFIFO_DEPTH. out_data is the registered array entry at the read pointer.
- The block has no FSM of its own; it is a pipelined register stage controlled one cycle at a time.

Optional Feature:
- Macro CPU_DATAPATH_CARRY_FLAG_EN.
- When defined:
  - Adds output port carry_flag (1 bit), reset 0.
  - On acc_enable with mux 00 and ADD/INC, carry_flag <= carry-out; with SUB/DEC, carry_flag <= borrow.
  - Any other accumulator load clears it.
- When undefined: port absent, no carry logic; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU_* localparams for the alu_select codes.
  - MUX_ALU/MUX_RF/MUX_IMM/MUX_IN for mux_select.
  - Opcode constants, so control_unit and cpu_datapath share one definition.
- One sub-module: cpu_alu (purely combinational; A, B, select, rotate in; result and carry out).
- FIFO stays inline.

Test Plan:
- Reset mid-stream with 3 FIFO entries held -> out_valid=0, zero_flag=1, all RF entries read 0 immediately after reset asserts.
- mux 10, imm_data=8'h05, acc_enable. Then rf_write addr 3. Then mux 10 imm 8'h03 with acc_enable. Then alu_select 0011 addr 3 with acc_enable -> acc=8'h08, positive_flag=1.
- acc=8'h01, alu_select 0110 with acc_enable -> acc=0, zero_flag=1. Repeat -> acc=8'hFF, positive_flag=0; carry_flag=1 when the macro is defined.
- acc=8'h81, alu_num_rotate=1, alu_select 0111 -> acc=8'hC0. Then SLT vs RF=8'h01 -> acc=8'h01.
- out_ready=0; five output_enable pulses with acc=1..5 -> first four buffered, out_overflow=1. Then out_ready=1 -> out_data sequence 1,2,3,4 and out_valid falls after 4.
- FIFO full with push and pop on the same edge -> count stays 4, no overflow, head advances.
